kfps2kb_keycode_queue: RTL and testbench
========================================

Name: kfps2kb_keycode_queue

Overview:
Parametrised successor to the simple PS/2 keyboard controller. It consumes bytes from the existing PS/2 shift register and translates scancode set 2 to set 1, including E0 extended sequences. Translated bytes are buffered in a DEPTH-entry FIFO rather than a single register, so fast typing no longer produces 0xFF errors. It sits between the shift register and the PPI/8259 keyboard IRQ path, and provides F11 pause handling and F12 suppression as parameters.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 4.
PAUSE_CODE, 8'h78, set-2 code whose break toggles pause_core (F11).
BLOCK_CODE, 8'h07, set-2 code that is always swallowed, make and break (F12, OSD).
ENABLE_EXTENDED, 1'b1, 1 = emit the E0 prefix for extended keys; 0 = drop E0 and translate the next byte as non-extended.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
register  in  8  received byte from shift register
recieved_flag  in  1  one-cycle strobe: register valid
recieved_error  in  1  one-cycle strobe: framing/parity error
irq  out  1  FIFO non-empty
keycode  out  8  FIFO head; 8'h00 when empty
clear_keycode  in  1  pop head (ack)
pause_core  out  1  core pause toggle
fifo_count  out  $clog2(DEPTH)+1  occupancy
overrun  out  1  sticky; cleared when the FIFO empties

Behaviour:
- Reset (synchronous, active-high) takes priority over everything and clears the following:
  - FIFO empty; irq=0, keycode=00, fifo_count=0, overrun=0, pause_core=0.
  - Decoder in IDLE; pending-code register cleared.
- Decoder FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen), EMIT (second byte of an extended code pending). It advances only on recieved_flag, except EMIT.
- Byte rules, applied in IDLE:
  - FA and FE are dropped.
  - F0 goes to BRK.
  - E0 goes to EXT.
  - Any other byte pushes conv(b), then returns to IDLE.
- BRK: on byte b, push conv(b)|80, then return to IDLE.
- EXT:
  - F0 goes to EXT_BRK.
  - 12 or 59 (fake shifts) are dropped; return to IDLE.
  - Otherwise push E0, latch conv(b) in the pending register, and go to EMIT.
- EXT_BRK:
  - 12 or 59 are dropped; return to IDLE.
  - Otherwise push E0, latch conv(b)|80, and go to EMIT.
- EMIT: push the pending byte on the next clock unconditionally, then return to IDLE. recieved_flag in this cycle is ignored; the PS/2 byte spacing guarantees it cannot occur.
- When ENABLE_EXTENDED=0, E0 is treated as dropped, the FSM goes to IDLE, and EMIT is never entered.
- Filtering, evaluated on the final byte of a sequence before any push:
  - Code == BLOCK_CODE: no push.
  - Code == PAUSE_CODE: no push; on break only, pause_core toggles.
  - pause_core=1: all other sequences are discarded with no push. For an extended sequence this means no E0 push either.
- recieved_error: push FF and force IDLE. It takes priority over a simultaneous recieved_flag. It is not filtered by pause.
- Latency: the push is registered at the clock edge where recieved_flag is sampled. irq and keycode are valid the next cycle. For an extended sequence, E0 is written at edge N and the second byte at N+1.
- FIFO rules:
  - irq = (fifo_count != 0); keycode = head entry.
  - clear_keycode while empty is ignored.
  - A simultaneous push and pop both occur and fifo_count is unchanged.
- Overrun rules:
  - A push with fifo_count == DEPTH-1 writes FF instead of the data and sets overrun.
  - A push with fifo_count == DEPTH is dropped.
  - A push and pop in the same cycle at DEPTH-1 writes the data normally.
  - overrun clears on the cycle fifo_count reaches 0.
- Pointers wrap modulo DEPTH; fifo_count saturates at DEPTH by construction.

Decomposition:
- Package kfps2kb_pkg holds:
  - constants PS2_BREAK=F0, PS2_EXT=E0, PS2_ACK=FA, PS2_RESEND=FE, KEY_OVERRUN=FF;
  - the decoder state enum;
  - function set2_to_set1(), the full 256-entry table.
- One sub-module, kfps2kb_sync_fifo: parameters DEPTH and WIDTH=8; ports push, pop, din, dout, count; synchronous reset.

Test Plan:
- Bytes 1C, then F0 1C, popping after each -> keycode 1E with irq, then 9E; fifo_count returns to 0.
- E0 75, no pop -> fifo_count=2, head E0; after pop the head is 48. Then E0 F0 75 -> E0, C8.
- DEPTH=4, push 1C 1B 23 24 15 with no pops -> FIFO holds 1E 1F 20 FF, overrun=1, 15 dropped; pop all -> overrun=0.
- F0 78 -> pause_core=1, nothing queued. 1C and E0 75 -> nothing queued. F0 78 -> pause_core=0. 1C -> 1E queued.
- F0, then recieved_error -> FF queued. Then 1C -> 1E (make, not break). 07 and F0 07 -> nothing queued.
- FIFO at count 2 with push and pop in the same cycle -> count stays 2 and order is preserved. Reset asserted during EMIT -> all outputs zero and the pending byte is not written.

Source files
------------

// File: rtl/kfps2kb_pkg.sv
// Shared constants, decoder states and the PS/2 scancode set 2 -> set 1 table
// used by the keycode queue.
package kfps2kb_pkg;

    localparam logic [7:0] PS2_BREAK   = 8'hF0;
    localparam logic [7:0] PS2_EXT     = 8'hE0;
    localparam logic [7:0] PS2_ACK     = 8'hFA;
    localparam logic [7:0] PS2_RESEND  = 8'hFE;
    localparam logic [7:0] KEY_OVERRUN = 8'hFF;
    localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_FAKE_RSHIFT = 8'h59;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK,
        ST_EMIT
    } dec_state_t;

    // Same translation the 8042 applies; the upper half is identity apart from 83/84.
    localparam logic [7:0] SET2_TBL [256] = '{
        8'hff, 8'h43, 8'h41, 8'h3f, 8'h3d, 8'h3b, 8'h3c, 8'h58,
        8'h64, 8'h44, 8'h42, 8'h40, 8'h3e, 8'h0f, 8'h29, 8'h59,
        8'h65, 8'h38, 8'h2a, 8'h70, 8'h1d, 8'h10, 8'h02, 8'h5a,
        8'h66, 8'h71, 8'h2c, 8'h1f, 8'h1e, 8'h11, 8'h03, 8'h5b,
        8'h67, 8'h2e, 8'h2d, 8'h20, 8'h12, 8'h05, 8'h04, 8'h5c,
        8'h68, 8'h39, 8'h2f, 8'h21, 8'h14, 8'h13, 8'h06, 8'h5d,
        8'h69, 8'h31, 8'h30, 8'h23, 8'h22, 8'h15, 8'h07, 8'h5e,
        8'h6a, 8'h72, 8'h32, 8'h24, 8'h16, 8'h08, 8'h09, 8'h5f,
        8'h6b, 8'h33, 8'h25, 8'h17, 8'h18, 8'h0b, 8'h0a, 8'h60,
        8'h6c, 8'h34, 8'h35, 8'h26, 8'h27, 8'h19, 8'h0c, 8'h61,
        8'h6d, 8'h73, 8'h28, 8'h74, 8'h1a, 8'h0d, 8'h62, 8'h6e,
        8'h3a, 8'h36, 8'h1c, 8'h1b, 8'h75, 8'h2b, 8'h63, 8'h76,
        8'h55, 8'h56, 8'h77, 8'h78, 8'h79, 8'h7a, 8'h0e, 8'h7b,
        8'h7c, 8'h4f, 8'h7d, 8'h4b, 8'h47, 8'h7e, 8'h7f, 8'h6f,
        8'h52, 8'h53, 8'h50, 8'h4c, 8'h4d, 8'h48, 8'h01, 8'h45,
        8'h57, 8'h4e, 8'h51, 8'h4a, 8'h37, 8'h49, 8'h46, 8'h54,
        8'h80, 8'h81, 8'h82, 8'h41, 8'h54, 8'h85, 8'h86, 8'h87,
        8'h88, 8'h89, 8'h8a, 8'h8b, 8'h8c, 8'h8d, 8'h8e, 8'h8f,
        8'h90, 8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97,
        8'h98, 8'h99, 8'h9a, 8'h9b, 8'h9c, 8'h9d, 8'h9e, 8'h9f,
        8'ha0, 8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6, 8'ha7,
        8'ha8, 8'ha9, 8'haa, 8'hab, 8'hac, 8'had, 8'hae, 8'haf,
        8'hb0, 8'hb1, 8'hb2, 8'hb3, 8'hb4, 8'hb5, 8'hb6, 8'hb7,
        8'hb8, 8'hb9, 8'hba, 8'hbb, 8'hbc, 8'hbd, 8'hbe, 8'hbf,
        8'hc0, 8'hc1, 8'hc2, 8'hc3, 8'hc4, 8'hc5, 8'hc6, 8'hc7,
        8'hc8, 8'hc9, 8'hca, 8'hcb, 8'hcc, 8'hcd, 8'hce, 8'hcf,
        8'hd0, 8'hd1, 8'hd2, 8'hd3, 8'hd4, 8'hd5, 8'hd6, 8'hd7,
        8'hd8, 8'hd9, 8'hda, 8'hdb, 8'hdc, 8'hdd, 8'hde, 8'hdf,
        8'he0, 8'he1, 8'he2, 8'he3, 8'he4, 8'he5, 8'he6, 8'he7,
        8'he8, 8'he9, 8'hea, 8'heb, 8'hec, 8'hed, 8'hee, 8'hef,
        8'hf0, 8'hf1, 8'hf2, 8'hf3, 8'hf4, 8'hf5, 8'hf6, 8'hf7,
        8'hf8, 8'hf9, 8'hfa, 8'hfb, 8'hfc, 8'hfd, 8'hfe, 8'hff
    };

    function automatic logic [7:0] set2_to_set1(input logic [7:0] code);
        return SET2_TBL[code];
    endfunction

endpackage

// File: rtl/kfps2kb_sync_fifo.sv
// Single-clock FIFO with synchronous reset; push when full and pop when empty
// are ignored.
module kfps2kb_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_rd  = pop && (r_count != '0);
    assign w_wr  = push && (r_count != (AW+1)'(DEPTH));
    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

    always_ff @(posedge clock) begin
        if (w_wr && !reset)
            r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/kfps2kb_keycode_queue.sv
// PS/2 set-2 byte stream to set-1 keycode queue with E0 handling, pause toggle,
// key blocking and an overrun marker in the FIFO.
module kfps2kb_keycode_queue
    import kfps2kb_pkg::*;
#(
    parameter int         DEPTH           = 8,
    parameter logic [7:0] PAUSE_CODE      = 8'h78,
    parameter logic [7:0] BLOCK_CODE      = 8'h07,
    parameter bit         ENABLE_EXTENDED = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              register,
    input  logic                    recieved_flag,
    input  logic                    recieved_error,
    output logic                    irq,
    output logic [7:0]              keycode,
    input  logic                    clear_keycode,
    output logic                    pause_core,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overrun
);
    localparam int CW = $clog2(DEPTH) + 1;

    dec_state_t    r_state, w_state_nxt;
    logic [7:0]    r_pend, w_pend_nxt;
    logic          r_pause, r_overrun;
    logic          w_pause_tgl, w_push, w_pop, w_mark, w_blocked, w_fake;
    logic [7:0]    w_push_data, w_conv, w_fifo_din, w_dout;
    logic [CW-1:0] w_count;

    assign w_conv    = set2_to_set1(register);
    assign w_blocked = (register == BLOCK_CODE) || (register == PAUSE_CODE) || r_pause;
    assign w_fake    = (register == PS2_FAKE_LSHIFT) || (register == PS2_FAKE_RSHIFT);

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_push      = 1'b0;
        w_push_data = 8'h00;
        w_pause_tgl = 1'b0;
        if (recieved_error) begin
            w_push      = 1'b1;
            w_push_data = KEY_OVERRUN;
            w_state_nxt = ST_IDLE;
        end else if (r_state == ST_EMIT) begin
            w_push      = 1'b1;
            w_push_data = r_pend;
            w_state_nxt = ST_IDLE;
        end else if (recieved_flag) begin
            w_state_nxt = ST_IDLE;
            case (r_state)
                ST_IDLE: begin
                    if (register == PS2_BREAK)
                        w_state_nxt = ST_BRK;
                    else if (register == PS2_EXT)
                        w_state_nxt = ENABLE_EXTENDED ? ST_EXT : ST_IDLE;
                    else if (register != PS2_ACK && register != PS2_RESEND) begin
                        w_push      = !w_blocked;
                        w_push_data = w_conv;
                    end
                end
                ST_BRK: begin
                    w_pause_tgl = (register == PAUSE_CODE);
                    w_push      = !w_blocked;
                    w_push_data = w_conv | 8'h80;
                end
                ST_EXT: begin
                    if (register == PS2_BREAK)
                        w_state_nxt = ST_EXT_BRK;
                    else if (!w_fake && !w_blocked) begin
                        w_push      = 1'b1;
                        w_push_data = PS2_EXT;
                        w_pend_nxt  = w_conv;
                        w_state_nxt = ST_EMIT;
                    end
                end
                ST_EXT_BRK: begin
                    if (!w_fake) begin
                        w_pause_tgl = (register == PAUSE_CODE);
                        if (!w_blocked) begin
                            w_push      = 1'b1;
                            w_push_data = PS2_EXT;
                            w_pend_nxt  = w_conv | 8'h80;
                            w_state_nxt = ST_EMIT;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // The last free slot is reserved for the FF marker unless a pop frees room.
    assign w_pop      = clear_keycode && (w_count != '0);
    assign w_mark     = w_push && !w_pop && (w_count == CW'(DEPTH - 1));
    assign w_fifo_din = w_mark ? KEY_OVERRUN : w_push_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pend    <= 8'h00;
            r_pause   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            if (w_pause_tgl)
                r_pause <= !r_pause;
            if (w_mark)
                r_overrun <= 1'b1;
            else if (w_pop && !w_push && w_count == CW'(1))
                r_overrun <= 1'b0;
        end
    end

    kfps2kb_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_fifo_din),
        .dout  (w_dout),
        .count (w_count)
    );

    assign irq        = (w_count != '0);
    assign keycode    = irq ? w_dout : 8'h00;
    assign fifo_count = w_count;
    assign overrun    = r_overrun;
    assign pause_core = r_pause;

endmodule

// File: tb/tb_kfps2kb_keycode_queue.sv
// Directed and randomized check of the keycode queue against a keystroke-level
// model: each key sequence maps to the list of set-1 bytes it should enqueue.
module tb_kfps2kb_keycode_queue;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] register = 8'h00;
    logic       recieved_flag = 1'b0;
    logic       recieved_error = 1'b0;
    logic       clear_keycode = 1'b0;
    logic       irq, pause_core, overrun;
    logic [7:0] keycode;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    bit         m_ovr = 0;
    bit         m_pause = 0;

    logic [7:0] norm_keys [10] = '{8'h1C, 8'h1B, 8'h23, 8'h24, 8'h15, 8'h1D, 8'h5A, 8'h29, 8'h76, 8'h0D};
    logic [7:0] ext_keys  [8]  = '{8'h75, 8'h6B, 8'h74, 8'h72, 8'h14, 8'h11, 8'h12, 8'h59};

    kfps2kb_keycode_queue #(.DEPTH(DEPTH), .PAUSE_CODE(8'h78), .BLOCK_CODE(8'h07),
                            .ENABLE_EXTENDED(1'b1)) dut (
        .clock          (clock),
        .reset          (reset),
        .register       (register),
        .recieved_flag  (recieved_flag),
        .recieved_error (recieved_error),
        .irq            (irq),
        .keycode        (keycode),
        .clear_keycode  (clear_keycode),
        .pause_core     (pause_core),
        .fifo_count     (fifo_count),
        .overrun        (overrun)
    );

    always #5 clock = ~clock;

    // Set-1 make codes for the keys the bench uses, taken from the PC key map.
    function automatic logic [7:0] ref_conv(input logic [7:0] c);
        case (c)
            8'h1C: return 8'h1E;  8'h1B: return 8'h1F;  8'h23: return 8'h20;
            8'h24: return 8'h12;  8'h15: return 8'h10;  8'h1D: return 8'h11;
            8'h5A: return 8'h1C;  8'h29: return 8'h39;  8'h76: return 8'h01;
            8'h0D: return 8'h0F;  8'h75: return 8'h48;  8'h6B: return 8'h4B;
            8'h74: return 8'h4D;  8'h72: return 8'h50;  8'h14: return 8'h1D;
            8'h11: return 8'h38;  8'h12: return 8'h2A;  8'h59: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (mq.size() == DEPTH) return;
        if (mq.size() == DEPTH - 1) begin
            mq.push_back(8'hFF);
            m_ovr = 1;
        end else
            mq.push_back(b);
    endfunction

    function automatic void model_pop();
        if (mq.size() != 0) begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_ovr = 0;
        end
    endfunction

    function automatic void model_key(input logic [7:0] code, input bit brk, input bit ext);
        logic [7:0] v;
        v = ref_conv(code) | (brk ? 8'h80 : 8'h00);
        if (code == 8'h07) return;
        if (code == 8'h78) begin
            if (brk) m_pause = !m_pause;
            return;
        end
        if (m_pause) return;
        if (ext) begin
            if (code == 8'h12 || code == 8'h59) return;
            model_push(8'hE0);
        end
        model_push(v);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"},   8'(fifo_count), 8'(mq.size()));
        chk({tag, ".irq"},     {7'd0, irq}, {7'd0, mq.size() != 0});
        chk({tag, ".keycode"}, keycode, (mq.size() != 0) ? mq[0] : 8'h00);
        chk({tag, ".overrun"}, {7'd0, overrun}, {7'd0, m_ovr});
        chk({tag, ".pause"},   {7'd0, pause_core}, {7'd0, m_pause});
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock); register = b; recieved_flag = 1'b1;
        @(negedge clock); recieved_flag = 1'b0;
        @(negedge clock);
    endtask

    task automatic send_key(input logic [7:0] code, input bit brk, input bit ext);
        if (ext) send_byte(8'hE0);
        if (brk) send_byte(8'hF0);
        send_byte(code);
        model_key(code, brk, ext);
    endtask

    task automatic send_err();
        @(negedge clock); recieved_error = 1'b1;
        @(negedge clock); recieved_error = 1'b0;
        model_push(8'hFF);
    endtask

    task automatic pop();
        @(negedge clock); clear_keycode = 1'b1;
        @(negedge clock); clear_keycode = 1'b0;
        model_pop();
    endtask

    task automatic push_pop(input logic [7:0] code);
        @(negedge clock); register = code; recieved_flag = 1'b1; clear_keycode = 1'b1;
        @(negedge clock); recieved_flag = 1'b0; clear_keycode = 1'b0;
        @(negedge clock);
        model_pop();
        model_push(ref_conv(code));
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_all("reset");

        // make then break, popping each
        send_key(8'h1C, 0, 0); check_all("make");
        pop();                 check_all("make_pop");
        send_key(8'h1C, 1, 0); check_all("break");
        pop();                 check_all("break_pop");

        // extended make and break
        send_key(8'h75, 0, 1); check_all("ext_make");
        pop();                 check_all("ext_make_pop1");
        pop();                 check_all("ext_make_pop2");
        send_key(8'h75, 1, 1); check_all("ext_brk");
        pop();                 check_all("ext_brk_pop1");
        pop();                 check_all("ext_brk_pop2");

        // fill to overrun
        send_key(8'h1C, 0, 0); send_key(8'h1B, 0, 0); send_key(8'h23, 0, 0);
        check_all("fill3");
        send_key(8'h24, 0, 0); check_all("ovr_mark");
        send_key(8'h15, 0, 0); check_all("ovr_drop");
        repeat (4) begin pop(); check_all("ovr_drain"); end
        pop();                 check_all("pop_empty");

        // pause handling
        send_key(8'h78, 1, 0); check_all("pause_on");
        send_key(8'h1C, 0, 0); send_key(8'h75, 0, 1); check_all("paused");
        send_key(8'h78, 0, 0); check_all("pause_make");
        send_key(8'h78, 1, 0); check_all("pause_off");
        send_key(8'h1C, 0, 0); check_all("unpaused");
        pop();

        // error mid-sequence, then blocked key
        send_byte(8'hF0); send_err(); check_all("err");
        pop();
        send_key(8'h1C, 0, 0); check_all("after_err");
        pop();
        send_key(8'h07, 0, 0); send_key(8'h07, 1, 0); check_all("block");

        // simultaneous push and pop at count 2 and DEPTH-1
        send_key(8'h1C, 0, 0); send_key(8'h1B, 0, 0);
        push_pop(8'h23);       check_all("pp2");
        send_key(8'h24, 0, 0); check_all("pp_fill3");
        push_pop(8'h15);       check_all("pp3");
        repeat (3) begin pop(); check_all("pp_drain"); end

        // reset while the second extended byte is pending
        send_key(8'h1C, 0, 0);
        @(negedge clock); register = 8'hE0; recieved_flag = 1'b1;
        @(negedge clock); recieved_flag = 1'b0;
        @(negedge clock); register = 8'h75; recieved_flag = 1'b1;
        @(negedge clock); recieved_flag = 1'b0; reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        mq.delete(); m_ovr = 0; m_pause = 0;
        check_all("rst_emit");
        @(negedge clock); check_all("rst_emit_hold");

        // randomized keystrokes with random acknowledges
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 6)       send_err();
            else if (r < 12) send_key(8'h78, 1'($urandom_range(0, 1)), 0);
            else if (r < 16) send_key(8'h07, 1'($urandom_range(0, 1)), 0);
            else if (r < 45) send_key(ext_keys[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), 1);
            else             send_key(norm_keys[$urandom_range(0, 9)], 1'($urandom_range(0, 1)), 0);
            check_all("rand");
            if ($urandom_range(0, 2) != 0) begin pop(); check_all("rand_pop"); end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
